// File: rtl/deconvolve_seq_if.sv
// Request/result bundle for deconvolve_seq: kernel and convolution result in,
// recovered sequence and sticky error flags out.
interface deconvolve_seq_if #(
    parameter int N = 3,
    parameter int M = 5
);
    logic                 start;
    logic [M-1:0][15:0]   arr_h;
    logic [N+M-2:0][31:0] arr_y;
    logic                 busy;
    logic                 done;
    logic [N-1:0][15:0]   arr_x;
    logic [3:0]           err;

    modport master (output start, arr_h, arr_y, input busy, done, arr_x, err);
    modport slave  (input start, arr_h, arr_y, output busy, done, arr_x, err);
endinterface

// File: rtl/deconvolve_seq.sv
// Recovers x from y = h * x by sequential polynomial long division (one MAC, bit-serial divider).
// Define DECONV_TAIL_CHECK_EN to also verify y[N..N+M-2] against h * x after the last quotient.
module deconvolve_seq #(
    parameter int N = 3,
    parameter int M = 5
) (
    input logic             clk,
    input logic             rst_n,
    deconvolve_seq_if.slave bus
);
    localparam int AW = 32 + $clog2(M);
    localparam int RW = 33 + $clog2(M);
    localparam int IW = $clog2(N + M + 1);
    localparam int KW = $clog2(M + 1);
    localparam int YN = N + M - 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CHK0, S_LOAD, S_ACCUM, S_DIV, S_STORE,
`ifdef DECONV_TAIL_CHECK_EN
        S_TAIL,
`endif
        S_FIN
    } state_t;

    state_t               state_q;
    logic [M-1:0][15:0]   h_q;
    logic [YN-1:0][31:0]  y_q;
    logic [N-1:0][15:0]   x_q;
    logic [3:0]           err_q;
    logic                 busy_q;
    logic                 done_q;
    logic [IW-1:0]        n_q;
    logic [KW-1:0]        k_q;
    logic [AW-1:0]        acc_q;
    logic [15:0]          drem_q;
    logic [31:0]          dquo_q;
    logic [4:0]           dcnt_q;

    int                   idx;
    int                   lim;
    logic [15:0]          h_sel;
    logic [15:0]          x_sel;
    logic [31:0]          y_sel;
    logic [AW-1:0]        acc_d;
    logic [AW-1:0]        acc_base;
    logic signed [RW-1:0] resid;
    logic                 go_div;
    logic [15:0]          drem_d;
    logic [31:0]          dquo_d;

    // One restoring-division step: shift the next dividend bit into the remainder.
    function automatic logic [47:0] div_step(input logic [15:0] rem, input logic [31:0] quo,
                                             input logic [15:0] d);
        logic [16:0] trial;
        logic        ge;
        trial    = {rem, quo[31]};
        ge       = (trial >= {1'b0, d});
        div_step = {ge ? 16'(trial - {1'b0, d}) : trial[15:0], quo[30:0], ge};
    endfunction

    always_comb begin
        idx   = int'(n_q) - int'(k_q);
        lim   = (int'(n_q) < M - 1) ? int'(n_q) : M - 1;
        h_sel = '0;
        x_sel = '0;
        y_sel = '0;
        // Out-of-range x indices read as zero so the tail sum needs no bound clipping.
        for (int i = 0; i < M; i++) if (int'(k_q) == i) h_sel = h_q[i];
        for (int i = 0; i < N; i++) if (idx == i) x_sel = x_q[i];
        for (int i = 0; i < YN; i++) if (int'(n_q) == i) y_sel = y_q[i];
        acc_d    = acc_q + AW'(32'(h_sel) * 32'(x_sel));
        go_div   = (state_q == S_LOAD && lim == 0) || (state_q == S_ACCUM && int'(k_q) == lim);
        acc_base = (state_q == S_ACCUM) ? acc_d : '0;
        resid    = $signed(RW'(y_sel)) - $signed(RW'(acc_base));
        {drem_d, dquo_d} = div_step(drem_q, dquo_q, h_q[0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            h_q     <= '0;
            y_q     <= '0;
            x_q     <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            n_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            drem_q  <= '0;
            dquo_q  <= '0;
            dcnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (bus.start) begin
                    h_q     <= bus.arr_h;
                    y_q     <= bus.arr_y;
                    x_q     <= '0;
                    err_q   <= '0;
                    n_q     <= '0;
                    busy_q  <= 1'b1;
                    state_q <= S_CHK0;
                end
                S_CHK0: if (h_q[0] == 16'd0) begin
                    err_q[0] <= 1'b1;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= S_FIN;
                end else begin
                    state_q <= S_LOAD;
                end
                S_LOAD, S_ACCUM: begin
                    acc_q <= (state_q == S_LOAD) ? '0 : acc_d;
                    k_q   <= (state_q == S_LOAD) ? KW'(1) : k_q + 1'b1;
                    if (go_div) begin
                        if (resid < 0) begin
                            err_q[3] <= 1'b1;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= S_FIN;
                        end else begin
                            drem_q  <= '0;
                            dquo_q  <= resid[31:0];
                            dcnt_q  <= '0;
                            state_q <= S_DIV;
                        end
                    end else begin
                        state_q <= S_ACCUM;
                    end
                end
                S_DIV: begin
                    drem_q <= drem_d;
                    dquo_q <= dquo_d;
                    dcnt_q <= dcnt_q + 1'b1;
                    if (dcnt_q == 5'd31) state_q <= S_STORE;
                end
                S_STORE: begin
                    if (drem_q != 16'd0 || dquo_q[31:16] != 16'd0) begin
                        if (drem_q != 16'd0) err_q[1] <= 1'b1;
                        else                 err_q[2] <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        for (int i = 0; i < N; i++) if (int'(n_q) == i) x_q[i] <= dquo_q[15:0];
                        if (int'(n_q) == N - 1) begin
`ifdef DECONV_TAIL_CHECK_EN
                            if (M > 1) begin
                                n_q     <= n_q + 1'b1;
                                k_q     <= KW'(1);
                                acc_q   <= '0;
                                state_q <= S_TAIL;
                            end else begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= S_FIN;
                            end
`else
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
`endif
                        end else begin
                            n_q     <= n_q + 1'b1;
                            state_q <= S_LOAD;
                        end
                    end
                end
`ifdef DECONV_TAIL_CHECK_EN
                // n_q is the tail index j; k runs j-N+1..M-1, then one compare cycle.
                S_TAIL: begin
                    if (int'(k_q) < M) begin
                        acc_q <= acc_d;
                        k_q   <= k_q + 1'b1;
                    end else if (acc_q != AW'(y_sel)) begin
                        err_q[3] <= 1'b1;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_FIN;
                    end else if (int'(n_q) == YN - 1) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        n_q   <= n_q + 1'b1;
                        k_q   <= KW'(int'(n_q) - N + 2);
                        acc_q <= '0;
                    end
                end
`endif
                S_FIN:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.arr_x = x_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_deconvolve_seq.sv
// Directed bench for deconvolve_seq (N=3, M=5): vector table plus FIN-start and mid-run reset sequences.
module tb_deconvolve_seq;
    localparam int N = 3;
    localparam int M = 5;
`ifdef DECONV_TAIL_CHECK_EN
    localparam bit TAIL_EN = 1'b1;
`else
    localparam bit TAIL_EN = 1'b0;
`endif
    localparam int TC = TAIL_EN ? 14 : 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    deconvolve_seq_if #(.N(N), .M(M)) bus ();
    deconvolve_seq #(.N(N), .M(M)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        string                name;
        logic [M-1:0][15:0]   h;
        logic [N+M-2:0][31:0] y;
        logic [N-1:0][15:0]   x;
        logic [3:0]           err;
        int                   cyc;
    } vec_t;

    vec_t vt[8];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse start with h/y, then scramble inputs and count cycles until done (cycle 1 = CHK0).
    task automatic run_case(input logic [M-1:0][15:0] h, input logic [N+M-2:0][31:0] y,
                            output int cyc, output logic busy1);
        @(negedge clk);
        bus.arr_h = h;
        bus.arr_y = y;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.arr_h = '1;
        bus.arr_y = '1;
        cyc   = 1;
        busy1 = bus.busy;
        while (!bus.done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.done) cyc = -1;
    endtask

    initial begin
        int   cyc;
        logic busy1;
        logic busy_seen;
        logic done_seen;
        logic [M-1:0][15:0]   h1;
        logic [N+M-2:0][31:0] y1;

        h1 = {16'd5, 16'd4, 16'd3, 16'd2, 16'd65535};
        y1 = {32'd5, 32'd9, 32'd12, 32'd9, 32'd65540, 32'd65537, 32'd65535};

        vt[0] = '{"basic", h1, y1, {16'd1, 16'd1, 16'd1}, 4'b0000, 107 + TC};
        vt[1] = '{"h0zero", {16'd5, 16'd4, 16'd3, 16'd2, 16'd0}, y1, '0, 4'b0001, 2};
        vt[2] = '{"remainder", h1, {32'd5, 32'd9, 32'd12, 32'd9, 32'd65540, 32'd65537, 32'd65536},
                  '0, 4'b0010, 36};
        vt[3] = '{"qoverflow", {16'd0, 16'd0, 16'd0, 16'd0, 16'd1},
                  {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd65536}, '0, 4'b0100, 36};
        vt[4] = '{"negresid", {16'd0, 16'd0, 16'd0, 16'd2, 16'd1},
                  {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd3, 32'd5},
                  {16'd0, 16'd0, 16'd5}, 4'b1000, 38};
        vt[5] = '{"tailbad", h1, {32'd6, 32'd9, 32'd12, 32'd9, 32'd65540, 32'd65537, 32'd65535},
                  {16'd1, 16'd1, 16'd1}, TAIL_EN ? 4'b1000 : 4'b0000, 107 + TC};
        vt[6] = '{"mixed", {16'd0, 16'd0, 16'd0, 16'd1, 16'd2},
                  {32'd0, 32'd0, 32'd0, 32'd3, 32'd11, 32'd17, 32'd14},
                  {16'd3, 16'd5, 16'd7}, 4'b0000, 107 + TC};
        vt[7] = '{"qmax", {16'd0, 16'd0, 16'd0, 16'd0, 16'd1},
                  {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd65535},
                  {16'd0, 16'd0, 16'd65535}, 4'b0000, 107 + TC};

        bus.start = 1'b0;
        bus.arr_h = '0;
        bus.arr_y = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_err", 64'(bus.err), 64'd0);
        check("reset_x", 64'(bus.arr_x), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_case(vt[i].h, vt[i].y, cyc, busy1);
            check({vt[i].name, "_cycle"}, 64'(cyc), 64'(vt[i].cyc));
            check({vt[i].name, "_busy1"}, 64'(busy1), 64'd1);
            check({vt[i].name, "_busydone"}, 64'(bus.busy), 64'd0);
            check({vt[i].name, "_x"}, 64'(bus.arr_x), 64'(vt[i].x));
            check({vt[i].name, "_err"}, 64'(bus.err), 64'(vt[i].err));
        end

        // start during the FIN cycle must be ignored; outputs hold while idle
        bus.arr_h = h1;
        bus.arr_y = y1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        busy_seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            busy_seen |= bus.busy;
        end
        check("finstart_busy", 64'(busy_seen), 64'd0);
        check("finstart_x", 64'(bus.arr_x), 64'(vt[7].x));
        check("finstart_err", 64'(bus.err), 64'd0);

        // reset in the middle of index 2's divide: x[0], x[1] already stored
        @(negedge clk);
        bus.arr_h = h1;
        bus.arr_y = y1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (79) @(negedge clk);
        check("pre_reset_x", 64'(bus.arr_x), 64'({16'd0, 16'd1, 16'd1}));
        rst_n = 1'b0;
        #1;
        check("midreset_busy", 64'(bus.busy), 64'd0);
        check("midreset_x", 64'(bus.arr_x), 64'd0);
        check("midreset_err", 64'(bus.err), 64'd0);
        done_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            done_seen |= bus.done;
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            done_seen |= bus.done;
        end
        check("midreset_nodone", 64'(done_seen), 64'd0);

        run_case(h1, y1, cyc, busy1);
        check("rerun_cycle", 64'(cyc), 64'(107 + TC));
        check("rerun_x", 64'(bus.arr_x), 64'({16'd1, 16'd1, 16'd1}));
        check("rerun_err", 64'(bus.err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
